// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, common command bytes
// and default timing constants (cycles at a 50 MHz clk_sys).
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        DATA,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
    localparam logic [7:0] PS2_CMD_EN_REPORT = 8'hF4;

    localparam int PS2_INHIBIT_CYC_DEF = 5000;     // 100 us
    localparam int PS2_TIMEOUT_CYC_DEF = 1000000;  // 20 ms

    // PS/2 frames carry odd parity: the parity bit makes the count of ones odd
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for an asynchronous PS/2 line plus a one-cycle
// falling-edge pulse derived from the synchronized value.
module ps2_sync_edge (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Reset to 1 (idle bus level) so leaving reset never fakes an edge
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], async_i};
            prev_q <= sync_q[1];
        end
    end

    assign sync_o = sync_q[1];
    assign fall_o = prev_q & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, request-to-send, 11-clock frame).
// Optional watchdog abort compiled in with `define PS2_TX_TIMEOUT_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = PS2_INHIBIT_CYC_DEF,
    parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC_DEF
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int IW = $clog2(INHIBIT_CYC + 1);

    ps2_state_e    state_q, state_d;
    logic [IW-1:0] inh_q, inh_d;
    logic [3:0]    edge_q, edge_d;
    logic [8:0]    shift_q, shift_d;
    logic          drv_q, drv_d;
    logic          nack_q, nack_d;
    logic          busy_q, busy_d;

    logic          clk_s, clk_fall, data_s;
    logic [1:0]    dsync_q;
    logic          timeout;

    ps2_sync_edge u_clk_sync (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .async_i (ps2_clk_in),
        .sync_o  (clk_s),
        .fall_o  (clk_fall)
    );

    // Data line only needs its synchronized level, never an edge
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) dsync_q <= 2'b11;
        else        dsync_q <= {dsync_q[0], ps2_data_in};
    end
    assign data_s = dsync_q[1];

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wdog_q;

    // Held at zero until START, so the count runs from the START cycle
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)
            wdog_q <= '0;
        else if (state_q == IDLE || state_q == INHIBIT || clk_fall)
            wdog_q <= '0;
        else if (!timeout)
            wdog_q <= wdog_q + 1'b1;
    end

    assign timeout = (state_q != IDLE) && (state_q != INHIBIT) &&
                     (wdog_q == TW'(TIMEOUT_CYC));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            inh_q   <= '0;
            edge_q  <= '0;
            shift_q <= '0;
            drv_q   <= 1'b0;
            nack_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inh_q   <= inh_d;
            edge_q  <= edge_d;
            shift_q <= shift_d;
            drv_q   <= drv_d;
            nack_q  <= nack_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        inh_d   = inh_q;
        edge_d  = edge_q;
        shift_d = shift_q;
        drv_d   = drv_q;
        nack_d  = nack_q;
        busy_d  = busy_q;
        tx_done = 1'b0;
        tx_err  = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_req && !busy_q) begin
                    shift_d = {odd_parity(tx_data), tx_data};
                    busy_d  = 1'b1;
                    nack_d  = 1'b0;
                    inh_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_q == IW'(INHIBIT_CYC - 1)) state_d = START;
                else                               inh_d   = inh_q + 1'b1;
            end
            START: begin
                // drv_q=1 keeps the start bit low once the clock is released
                edge_d  = '0;
                inh_d   = '0;
                drv_d   = 1'b1;
                state_d = DATA;
            end
            DATA: begin
                if (clk_fall) begin
                    edge_d = edge_q + 1'b1;
                    if (edge_q == 4'd9) begin
                        drv_d   = 1'b0;
                        state_d = ACK;
                    end else begin
                        drv_d   = ~shift_q[0];
                        shift_d = {1'b0, shift_q[8:1]};
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    edge_d  = edge_q + 1'b1;
                    nack_d  = data_s;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // tx_done is combinational so busy is still high in the done cycle
                if (clk_s && data_s) begin
                    tx_done = 1'b1;
                    tx_err  = nack_q;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            tx_done = 1'b1;
            tx_err  = 1'b1;
            busy_d  = 1'b0;
            drv_d   = 1'b0;
            state_d = IDLE;
        end
    end

    assign tx_busy     = busy_q;
    assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == START);
    assign ps2_data_oe = ((state_q == START) || (state_q == DATA && drv_q)) && !timeout;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx: a behavioural PS/2 device captures frames,
// a scoreboard queue holds expected results, a monitor checks each tx_done.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 40;
    localparam int TMO  = 3000;
    localparam int HALF = 12;

    typedef struct {
        logic [7:0] b;
        bit         nack;
        bit         frame;
    } exp_t;

    logic       clk_sys = 1'b0;
    logic       rst_n   = 1'b0;
    logic       tx_req  = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;

    assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .tx_req      (tx_req),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk_sys = ~clk_sys;

    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   nexp = 0;
    int   inh_run = 0;
    int   inh_len = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [7:0] obs_b;
    logic obs_par, obs_stop, obs_drive;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Odd parity from the frame rule: parity bit is 1 when the data has an even count of ones
    function automatic logic ref_par(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    // Length of the clock-only inhibit phase preceding the request-to-send
    always @(negedge clk_sys) begin
        if (!ps2_clk_oe)       inh_run <= 0;
        else if (!ps2_data_oe) inh_run <= inh_run + 1;
        else                   inh_len <= inh_run;
    end

    always @(negedge clk_sys) begin
        if (tx_err) check("err_with_done", tx_done, 1);
        if (tx_done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("busy_at_done", tx_busy, 1);
                check("tx_err", tx_err, mon_e.nack);
                if (mon_e.frame) begin
                    check("frame_byte", obs_b, mon_e.b);
                    check("frame_parity", obs_par, ref_par(mon_e.b));
                    check("frame_stop", obs_stop, 1);
                    check("data_driven", obs_drive, (mon_e.b != 8'hFF) || !ref_par(mon_e.b));
                end
            end
        end
    end

    task automatic pulse_req(input logic [7:0] b);
        @(negedge clk_sys);
        tx_req  = 1'b1;
        tx_data = b;
        @(negedge clk_sys);
        tx_req  = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit nack);
        exp_t e;
        e.b = b; e.nack = nack; e.frame = 1'b1;
        exp_q.push_back(e);
        nexp++;
        pulse_req(b);
        check("busy_set", tx_busy, 1);
    endtask

    // Device side: clocks nclk falling edges, samples data on rising edges,
    // answers edge 11 with ACK (data low) or NACK (data left high)
    task automatic dev_xfer(input bit nack, input int nclk);
        int w = 0;
        while (!(!ps2_clk_oe && ps2_data_oe) && w < 3000) begin
            @(negedge clk_sys);
            w++;
        end
        check("rts_seen", w < 3000, 1);
        if (w >= 3000) return;
        check("inhibit_len", inh_len, INH);
        check("start_bit", ps2_data_in, 0);
        obs_drive = 1'b0;
        repeat (HALF) @(negedge clk_sys);
        for (int i = 1; i <= nclk; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk_sys);
            if (i <= 9 && ps2_data_oe) obs_drive = 1'b1;
            dev_clk = 1'b1;
            if (i <= 8)       obs_b[i-1] = ps2_data_in;
            else if (i == 9)  obs_par    = ps2_data_in;
            else if (i == 10) obs_stop   = ps2_data_in;
            repeat (HALF) @(negedge clk_sys);
            if (i == 10) dev_data = nack;
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_done(input int n, input int budget);
        int w = 0;
        while (done_cnt < n && w < budget) begin
            @(negedge clk_sys);
            w++;
        end
        check("done_seen", done_cnt >= n, 1);
    endtask

    initial begin
        logic [7:0] b;
        bit         nk;
        int         saved;

        #12;
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_err", tx_err, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_sys);

        send(PS2_CMD_EN_REPORT, 0);
        dev_xfer(0, 11);
        wait_done(nexp, 2000);

        send(PS2_CMD_RESET, 0);
        dev_xfer(0, 11);
        wait_done(nexp, 2000);

        b = 8'($urandom);
        send(b, 1);
        dev_xfer(1, 11);
        wait_done(nexp, 2000);

        // Second request while busy must not be queued or transmitted
        b = 8'($urandom);
        send(b, 0);
        pulse_req(8'h00);
        check("busy_hold", tx_busy, 1);
        dev_xfer(0, 11);
        wait_done(nexp, 2000);
        repeat (100) @(negedge clk_sys);
        check("no_second_xfer_clk", ps2_clk_oe, 0);
        check("no_second_xfer_busy", tx_busy, 0);

        for (int k = 0; k < 6; k++) begin
            b  = 8'($urandom);
            nk = 1'($urandom_range(0, 1));
            send(b, nk);
            dev_xfer(nk, 11);
            wait_done(nexp, 2000);
            repeat ($urandom_range(1, 20)) @(negedge clk_sys);
        end

        // Reset in the middle of the data phase abandons the transfer silently
        saved = done_cnt;
        send(8'h5A, 0);
        dev_xfer(0, 4);
        @(negedge clk_sys);
        rst_n = 1'b0;
        #1;
        check("midrst_clk_oe", ps2_clk_oe, 0);
        check("midrst_data_oe", ps2_data_oe, 0);
        check("midrst_busy", tx_busy, 0);
        exp_q.delete();
        nexp = saved;
        repeat (5) @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (50) @(negedge clk_sys);
        check("midrst_no_done", done_cnt, saved);
        b = 8'($urandom);
        send(b, 0);
        dev_xfer(0, 11);
        wait_done(nexp, 2000);

        // Device never clocks after request-to-send
        saved = done_cnt;
`ifdef PS2_TX_TIMEOUT_EN
        begin
            exp_t e;
            e.b = 8'h00; e.nack = 1'b1; e.frame = 1'b0;
            exp_q.push_back(e);
            nexp++;
        end
        pulse_req(8'hA5);
        dev_xfer(0, 0);
        wait_done(nexp, TMO + 500);
        @(negedge clk_sys);
        check("tmo_clk_oe", ps2_clk_oe, 0);
        check("tmo_data_oe", ps2_data_oe, 0);
        check("tmo_busy", tx_busy, 0);
`else
        pulse_req(8'hA5);
        dev_xfer(0, 0);
        repeat (TMO + 200) @(negedge clk_sys);
        check("stall_busy", tx_busy, 1);
        check("stall_no_done", done_cnt, saved);
        rst_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
`endif
        repeat (20) @(negedge clk_sys);
        check("queue_empty", exp_q.size(), 0);
        check("done_total", done_cnt, nexp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
